// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with saturating match counter.
// Latency: Y and cfg_err are registered, asserted the cycle after the accepting edge.
// No backpressure: every en-qualified bit is consumed; cfg_load pre-empts the stream bit.
module seq_det_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 10,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               Y,
  output logic [CNT_W-1:0]   count,
  output logic               cnt_sat,
  output logic               cfg_err
);

  localparam logic [LEN_W:0] MAX_LEN_V = (LEN_W + 1)'(MAX_LEN);

  // Active configuration and stream history
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [MAX_LEN-1:0] hist_q;
  logic [LEN_W-1:0]   fill_q;

  // Next-state helpers
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_nxt;
  logic               cfg_ok;
  logic               step;
  logic               match;
  logic [CNT_W-1:0]   cnt_nxt;

  // Mask selecting the low len_q bits of history and pattern; upper bits are don't-care
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = ({1'b0, len_q} > (LEN_W + 1)'(i));
    end
  end

  // Stream step, match detection and fill-counter update
  always_comb begin
    cfg_ok   = (cfg_len != '0) && ({1'b0, cfg_len} <= MAX_LEN_V);
    step     = en && !cfg_load;
    hist_nxt = {hist_q[MAX_LEN-2:0], x};
    fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);
    // fill+1 >= len means the new bit completes a window of len fresh bits
    match    = step && (fill_inc >= {1'b0, len_q}) &&
               ((hist_nxt & len_mask) == (pat_q & len_mask));
    if (match && !ovl_q) begin
      // Non-overlapping: the next match must be built from entirely new bits
      fill_nxt = '0;
    end else if (fill_inc >= {1'b0, len_q}) begin
      fill_nxt = len_q;
    end else begin
      fill_nxt = fill_inc[LEN_W-1:0];
    end
  end

  // Counter next value: clear wins over a same-cycle match; saturate at all ones
  always_comb begin
    cnt_nxt = count;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (match && !(&count)) begin
      cnt_nxt = count + CNT_W'(1);
    end
  end

  // Configuration, history and fill registers; cfg_load takes priority over the stream
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q  <= MAX_LEN'(3'b010);
      len_q  <= LEN_W'(3);
      ovl_q  <= 1'b1;
      hist_q <= '0;
      fill_q <= '0;
    end else if (cfg_load) begin
      if (cfg_ok) begin
        pat_q  <= cfg_pattern;
        len_q  <= cfg_len;
        ovl_q  <= cfg_overlap;
        hist_q <= '0;
        fill_q <= '0;
      end
    end else if (en) begin
      hist_q <= hist_nxt;
      fill_q <= fill_nxt;
    end
  end

  // Registered status outputs: match pulse, config error pulse, counter and saturation flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      Y       <= 1'b0;
      cfg_err <= 1'b0;
      count   <= '0;
      cnt_sat <= 1'b0;
    end else begin
      Y       <= match;
      cfg_err <= cfg_load && !cfg_ok;
      count   <= cnt_nxt;
      cnt_sat <= &cnt_nxt;
    end
  end

endmodule

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
- Runtime-programmable serial bit-pattern detector; next generation of the fixed 3-bit "010" sequence detector.
- Pattern value and length up to MAX_LEN are loaded at runtime; overlapping or non-overlapping matching is selectable.
- Bits are qualified by an enable. Matches raise a one-cycle flag and increment a saturating match counter.
- Sits on a serial bit stream in the verification lab designs; status is read by a bench or host.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32)
- CNT_W, 10, match counter width
- LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; do not override)

Ports:
- clk, input, 1, rising-edge clock; single clock domain
- rst, input, 1, synchronous active-low reset (sampled on clk rising edge; 0 = reset)
- en, input, 1, x is a valid stream bit this cycle
- x, input, 1, serial data bit
- cfg_load, input, 1, latch cfg_pattern/cfg_len/cfg_overlap this cycle
- cfg_pattern, input, MAX_LEN, pattern; bit [len-1] is the earliest received bit, bit [0] the latest
- cfg_len, input, LEN_W, pattern length; legal range 1..MAX_LEN
- cfg_overlap, input, 1, 1 = overlapping matches, 0 = non-overlapping
- cnt_clr, input, 1, synchronous clear of count
- Y, output, 1, registered one-cycle match pulse
- count, output, CNT_W, number of matches since reset/clear (saturating)
- cnt_sat, output, 1, high while count equals all ones
- cfg_err, output, 1, one-cycle pulse: cfg_load with illegal cfg_len

Behaviour:
- Reset (rst=0 at clk edge) values:
  - Y=0, count=0, cnt_sat=0, cfg_err=0.
  - History register hist=0; fill counter fill=0.
  - Active config: pattern=3'b010 (zero-extended), len=3, overlap=1.
- Stream step (en=1, cfg_load=0):
  - hist <= {hist[MAX_LEN-2:0], x}.
  - fill <= min(fill+1, len).
- Match condition, evaluated on the updated values: (fill+1 >= len) and hist_next[len-1:0] == pattern[len-1:0]. Bits above len are ignored.
- Latency: Y=1 in the cycle after the clk edge that accepted the completing bit. Y is high for exactly one cycle per match and is 0 whenever en was 0 in the prior cycle.
- Overlap=1: fill is kept after a match, so 0101010 with pattern 010 gives 3 matches.
- Overlap=0: fill is set to 0 on a match, so the next match needs len fresh bits; 0101010 with pattern 010 gives 2 matches.
- en=0: hist, fill and count hold; Y=0 next cycle.
- Count:
  - Increments by 1 on each match.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat = (count == all ones), registered together with count.
- cnt_clr=1:
  - count <= 0 and cnt_sat <= 0.
  - Has priority over a same-cycle match: count ends at 0, the match is not counted, but Y still pulses.
  - Does not touch hist or fill.
- cfg_load=1 with 1 <= cfg_len <= MAX_LEN:
  - Active config <= inputs; hist <= 0; fill <= 0.
  - Any same-cycle en/x is discarded; no match is evaluated that cycle.
  - count is unaffected.
- cfg_load=1 with cfg_len = 0 or cfg_len > MAX_LEN:
  - Config, hist and fill unchanged.
  - cfg_err=1 next cycle for one cycle.
  - Same-cycle en/x is discarded.
- len=1: every accepted bit equal to pattern[0] produces a match, in either overlap mode.
- Reset asserted mid-pattern: partial history is lost; a pattern completed on the reset cycle does not pulse Y.
- Priority at each clk edge: rst > cfg_load > stream step; cnt_clr is applied orthogonally to count.

Test Plan:
- Default config after reset, en=1, x=0,1,0,1,0:
  - Y pulses one cycle after the 3rd and 5th bits; count=2.
  - Then cnt_clr=1 -> count=0.
- Load pattern=8'b1011_0110, len=8, overlap=0; stream 1,0,1,1,0,1,1,0,1,1,0:
  - One pulse after bit 8; count=1; no match at bit 11 (fill reset).
  - Repeat with overlap=1: pulses after bits 8 and 11; count=2.
- Default config, stream 0,1,0 with en=0 for 3 cycles inserted between 1 and 0:
  - Single Y pulse one cycle after the final accepted 0.
  - Y=0 during all idle cycles.
- CNT_W=3, len=1, pattern=1, stream nine 1s:
  - count goes 1..7 and sticks at 7; cnt_sat=1 from the 7th match onward.
  - cnt_clr on the 9th match cycle -> count=0 and Y=1.
- cfg_load with cfg_len=0, then cfg_len=9 (MAX_LEN=8):
  - cfg_err pulses each time; config unchanged, since default 010 still detected.
  - cfg_load with len=2 mid-stream discards the accompanying bit and clears history.
- Stream 0,1 then rst=0 on the cycle x=0 is presented:
  - No Y pulse; all outputs at reset values.
  - Detection resumes normally after rst=1.
